// File: rtl/dti_join_if.sv
// dti valid/ready channel: producer drives valid/data, consumer drives ready.
interface dti #(
  parameter int unsigned W = 8
) ();
  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport producer (output valid, output data, input ready);
  modport consumer (input valid, input data, output ready);
endinterface

// File: rtl/dti_join.sv
// Many-to-one synchronising join: one holding slot per input channel; fires a
// single concatenated output once every slot is full.
module dti_join #(
  parameter int unsigned SIZE   = 2,
  parameter int unsigned W_DATA = 8
) (
  input  logic clk,
  input  logic rst,
  dti.consumer din [SIZE-1:0],
  dti.producer dout
);

  logic [SIZE-1:0]        full;
  logic [SIZE-1:0]        rdy;
  logic [SIZE-1:0]        vld;
  logic [SIZE-1:0]        in_hs;
  logic [SIZE*W_DATA-1:0] hold;
  logic [SIZE*W_DATA-1:0] in_data;
  logic                   out_hs;

  for (genvar g = 0; g < SIZE; g++) begin : g_chan
    assign vld[g]                      = din[g].valid;
    assign in_data[g*W_DATA +: W_DATA] = din[g].data;
    assign din[g].ready                = rdy[g];
  end

  assign dout.valid = &full;
  assign dout.data  = hold;

  // Only dout.ready reaches din.ready combinationally; din.valid never does.
  always_comb begin
    out_hs = '0;
    rdy    = '0;
    in_hs  = '0;
    out_hs = (&full) & dout.ready;
    rdy    = ~full | {SIZE{out_hs}};
    in_hs  = vld & rdy;
  end

  // A capture wins over the join clearing the slot, so a slot refills seamlessly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full <= '0;
      hold <= '0;
    end else begin
      for (int unsigned i = 0; i < SIZE; i++) begin
        if (in_hs[i]) begin
          full[i]                    <= 1'b1;
          hold[i*W_DATA +: W_DATA]   <= in_data[i*W_DATA +: W_DATA];
        end else if (out_hs) begin
          full[i]                    <= 1'b0;
        end
      end
    end
  end

endmodule
